// File: rtl/bidir_link_ctrl_if.sv
// Handshake and pin-stage bundle for bidir_link_ctrl.
// master = requester/pin stage side, slave = the controller.
interface bidir_link_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             wr;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] rdata;
   logic             dir;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] data_in;

   modport master (
      output start, wr, wdata, data_in,
      input  busy, done, rdata, dir, data_out
   );

   modport slave (
      input  start, wr, wdata, data_in,
      output busy, done, rdata, dir, data_out
   );
endinterface

// File: rtl/bidir_link_ctrl.sv
// Half-duplex serial link controller: drives a frame MSB first, or releases the pin,
// waits a turnaround and samples a frame back in. All outputs are registered.
module bidir_link_ctrl #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4,
   parameter int TA_CYCLES  = 2
) (
   input logic              clk,
   input logic              rst_n,
   bidir_link_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_TURN   = 2'd2;
   localparam logic [1:0] S_SAMPLE = 2'd3;

   localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int TCW = (TA_CYCLES  > 1) ? $clog2(TA_CYCLES)  : 1;
   localparam int ICW = (WIDTH      > 1) ? $clog2(WIDTH)      : 1;

   localparam logic [BCW-1:0] BC_LAST = BCW'(BIT_CYCLES - 1);
   localparam logic [TCW-1:0] TA_LAST = TCW'(TA_CYCLES - 1);
   localparam logic [ICW-1:0] IX_LAST = ICW'(WIDTH - 1);

   logic [1:0]       state_q,  state_d;
   logic [BCW-1:0]   bitcnt_q, bitcnt_d;
   logic [TCW-1:0]   tacnt_q,  tacnt_d;
   logic [ICW-1:0]   bitidx_q, bitidx_d;
   logic [WIDTH-1:0] sh_q,     sh_d;
   logic             wr_q,     wr_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             dir_q,    dir_d;
   logic [WIDTH-1:0] dout_q,   dout_d;
   logic [WIDTH-1:0] rdata_q,  rdata_d;

   // Only lane 0 of the read-back bus carries data.
   logic unused_lanes;
   assign unused_lanes = ^bus.data_in;

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      tacnt_d  = tacnt_q;
      bitidx_d = bitidx_q;
      sh_d     = sh_q;
      wr_d     = wr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rdata_d  = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               wr_d     = bus.wr;
               sh_d     = bus.wdata;
               bitcnt_d = '0;
               tacnt_d  = '0;
               bitidx_d = '0;
               busy_d   = 1'b1;
               state_d  = bus.wr ? S_DRIVE : S_TURN;
            end
         end
         S_DRIVE: begin
            if (bitcnt_q == BC_LAST) begin
               bitcnt_d = '0;
               if (bitidx_q == IX_LAST) begin
                  bitidx_d = '0;
                  state_d  = S_TURN;
               end else begin
                  bitidx_d = bitidx_q + ICW'(1);
                  sh_d     = sh_q << 1;
               end
            end else begin
               bitcnt_d = bitcnt_q + BCW'(1);
            end
         end
         S_TURN: begin
            if (tacnt_q == TA_LAST) begin
               tacnt_d = '0;
               if (wr_q) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_SAMPLE;
               end
            end else begin
               tacnt_d = tacnt_q + TCW'(1);
            end
         end
         default: begin
            // Sample on the last clock of each bit period, shifting in MSB first.
            if (bitcnt_q == BC_LAST) begin
               bitcnt_d = '0;
               sh_d     = (sh_q << 1) | WIDTH'(bus.data_in[0]);
               if (bitidx_q == IX_LAST) begin
                  bitidx_d = '0;
                  state_d  = S_IDLE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  rdata_d  = sh_d;
               end else begin
                  bitidx_d = bitidx_q + ICW'(1);
               end
            end else begin
               bitcnt_d = bitcnt_q + BCW'(1);
            end
         end
      endcase

      // Pin outputs are decoded from the next state so they line up with it.
      dir_d  = (state_d == S_DRIVE);
      dout_d = (state_d == S_DRIVE) ? {WIDTH{sh_d[WIDTH-1]}} : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         bitcnt_q <= '0;
         tacnt_q  <= '0;
         bitidx_q <= '0;
         sh_q     <= '0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dir_q    <= 1'b0;
         dout_q   <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         tacnt_q  <= tacnt_d;
         bitidx_q <= bitidx_d;
         sh_q     <= sh_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dir_q    <= dir_d;
         dout_q   <= dout_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.dir      = dir_q;
   assign bus.data_out = dout_q;
   assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Directed + randomized bench for bidir_link_ctrl; expected pin activity is derived
// from the frame timeline (bit j of the transaction at a given clock offset).
module tb_bidir_link_ctrl;

   localparam int W = 8;
   localparam int B = 4;
   localparam int T = 2;
   localparam int L = W * B + T;   // offset of the done cycle from the acceptance edge

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bidir_link_ctrl_if #(.WIDTH(W)) bus0 ();
   bidir_link_ctrl_if #(.WIDTH(1)) bus1 ();

   bidir_link_ctrl #(.WIDTH(W), .BIT_CYCLES(B), .TA_CYCLES(T)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   bidir_link_ctrl #(.WIDTH(1), .BIT_CYCLES(1), .TA_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int n_chk  = 0;
   int n_fail = 0;
   logic         pend;
   logic [W-1:0] exp_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction on dut0. Offset j counts clocks after the acceptance edge
   // (j=0 is the cycle right after it); outputs are checked mid-cycle.
   task automatic run_txn(input bit w, input logic [W-1:0] d, input logic [W-1:0] pat,
                          input bit noise, input bit nxt, input bit nxt_w,
                          input logic [W-1:0] nxt_d);
      logic         edir, ebusy, edone, bitv;
      logic [W-1:0] edout;
      if (!pend) begin
         bus0.start = 1'b1; bus0.wr = w; bus0.wdata = d;
      end
      @(posedge clk);
      pend = 1'b0;
      #1;
      bus0.start = 1'b0;
      bus0.wr    = 1'($urandom);
      bus0.wdata = W'($urandom);
      for (int j = 0; j <= L; j++) begin
         @(negedge clk);
         edir = 1'b0; edout = '0; ebusy = (j < L); edone = (j == L);
         if (w && j < W * B) begin
            bitv  = d[W-1-(j/B)];
            edir  = 1'b1;
            edout = {W{bitv}};
         end
         if (!w && j == L) exp_rdata = pat;
         chk($sformatf("dir%s j=%0d", w ? "W" : "R", j), 32'(bus0.dir), 32'(edir));
         chk($sformatf("dout j=%0d", j), 32'(bus0.data_out), 32'(edout));
         chk($sformatf("busy j=%0d", j), 32'(bus0.busy), 32'(ebusy));
         chk($sformatf("done j=%0d", j), 32'(bus0.done), 32'(edone));
         chk($sformatf("rdata j=%0d", j), 32'(bus0.rdata), 32'(exp_rdata));
         bus0.data_in = W'($urandom);
         if (!w && j >= T && j < L && ((j - T) % B) == B - 1)
            bus0.data_in[0] = pat[W-1-((j-T)/B)];
         if (j < L) begin
            bus0.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end else if (nxt) begin
            bus0.start = 1'b1; bus0.wr = nxt_w; bus0.wdata = nxt_d; pend = 1'b1;
         end else begin
            bus0.start = 1'b0;
         end
      end
   endtask

   initial begin
      bit           cw, nw, ch, b;
      logic [W-1:0] cd, nd;
      rst_n = 1'b0; pend = 1'b0; exp_rdata = '0;
      bus0.start = 1'b0; bus0.wr = 1'b0; bus0.wdata = '0; bus0.data_in = '0;
      bus1.start = 1'b0; bus1.wr = 1'b0; bus1.wdata = '0; bus1.data_in = '0;
      #1;
      chk("rst busy", 32'(bus0.busy), 32'd0);
      chk("rst done", 32'(bus0.done), 32'd0);
      chk("rst dir", 32'(bus0.dir), 32'd0);
      chk("rst dout", 32'(bus0.data_out), 32'd0);
      chk("rst rdata", 32'(bus0.rdata), 32'd0);
      chk("rst1 rdata", 32'(bus1.rdata), 32'd0);
      chk("rst1 dir", 32'(bus1.dir), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_txn(1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      run_txn(1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, '0);

      // Back-to-back write -> read -> write with start held across the done cycle.
      run_txn(1'b1, W'($urandom), '0, 1'b0, 1'b1, 1'b0, '0);
      run_txn(1'b0, '0, W'($urandom), 1'b0, 1'b1, 1'b1, 8'h96);
      run_txn(1'b1, 8'h96, '0, 1'b0, 1'b0, 1'b0, '0);

      cw = 1'($urandom); cd = W'($urandom);
      for (int i = 0; i < 6; i++) begin
         nw = 1'($urandom); nd = W'($urandom); ch = 1'($urandom);
         run_txn(cw, cd, W'($urandom), 1'b1, ch && (i < 5), nw, nd);
         cw = nw; cd = nd;
      end

      // Abort a write in mid-frame.
      @(negedge clk);
      bus0.start = 1'b1; bus0.wr = 1'b1; bus0.wdata = 8'hFF;
      @(posedge clk);
      #1 bus0.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre-abort dir", 32'(bus0.dir), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort dir", 32'(bus0.dir), 32'd0);
      chk("abort dout", 32'(bus0.data_out), 32'd0);
      chk("abort busy", 32'(bus0.busy), 32'd0);
      chk("abort rdata", 32'(bus0.rdata), 32'd0);
      exp_rdata = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort done", 32'(bus0.done), 32'd0);
      end
      rst_n = 1'b1;
      bus0.start = 1'b1; bus0.wr = 1'b1; bus0.wdata = 8'h5A; pend = 1'b1;
      run_txn(1'b1, 8'h5A, '0, 1'b0, 1'b0, 1'b0, '0);

      // Minimal configuration: 1 bit, 1 clock per bit, 1 turnaround clock.
      for (int k = 0; k < 4; k++) begin
         b = (k < 2) ? k[0] : 1'($urandom);
         @(negedge clk);
         bus1.start = 1'b1; bus1.wr = 1'b0; bus1.wdata = 1'($urandom);
         @(posedge clk);
         #1 bus1.start = 1'b0;
         @(negedge clk);
         chk("w1 busy j0", 32'(bus1.busy), 32'd1);
         chk("w1 dir j0", 32'(bus1.dir), 32'd0);
         chk("w1 done j0", 32'(bus1.done), 32'd0);
         bus1.data_in = ~b;
         @(negedge clk);
         chk("w1 dir j1", 32'(bus1.dir), 32'd0);
         chk("w1 done j1", 32'(bus1.done), 32'd0);
         bus1.data_in = b;
         @(negedge clk);
         chk("w1 done j2", 32'(bus1.done), 32'd1);
         chk("w1 busy j2", 32'(bus1.busy), 32'd0);
         chk("w1 rdata", 32'(bus1.rdata), 32'(b));
         bus1.data_in = 1'($urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
